// File: rtl/toy_bus_ack_arb4_locked.sv
// Four-requester arbiter with age-matrix fairness and packet locking: once a
// multi-beat packet starts, only its owner is granted until its last beat.
module toy_bus_ack_arb4_locked #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic              in0_opcode,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [9:0]        in0_sideband,
  input  logic [3:0]        in0_src_id,
  input  logic [3:0]        in0_tgt_id,
  input  logic              in1_vld,
  output logic              in1_rdy,
  input  logic              in1_opcode,
  input  logic [DATA_W-1:0] in1_data,
  input  logic [9:0]        in1_sideband,
  input  logic [3:0]        in1_src_id,
  input  logic [3:0]        in1_tgt_id,
  input  logic              in2_vld,
  output logic              in2_rdy,
  input  logic              in2_opcode,
  input  logic [DATA_W-1:0] in2_data,
  input  logic [9:0]        in2_sideband,
  input  logic [3:0]        in2_src_id,
  input  logic [3:0]        in2_tgt_id,
  input  logic              in3_vld,
  output logic              in3_rdy,
  input  logic              in3_opcode,
  input  logic [DATA_W-1:0] in3_data,
  input  logic [9:0]        in3_sideband,
  input  logic [3:0]        in3_src_id,
  input  logic [3:0]        in3_tgt_id,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_opcode,
  output logic [DATA_W-1:0] out_data,
  output logic [9:0]        out_sideband,
  output logic [3:0]        out_src_id,
  output logic [3:0]        out_tgt_id,
  output logic [1:0]        out_grant_id
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [N_IN-1:0]   vld;
  logic [N_IN-1:0]   opc;
  logic [N_IN-1:0]   sel;
  logic [N_IN-1:0]   lock_mask;
  logic [N_IN-1:0]   grant;
  logic [N_IN-1:0]   rdy;
  logic [DATA_W-1:0] data  [N_IN];
  logic [9:0]        sband [N_IN];
  logic [3:0]        src   [N_IN];
  logic [3:0]        tgt   [N_IN];
  logic [N_IN-1:0]   age   [N_IN];
  logic [0:0]        state;
  logic [1:0]        lock_id;
  logic [1:0]        acc_idx;
  logic              stg_rdy;
  logic              accepted;
  logic              acc_opc;

  assign vld = {in3_vld, in2_vld, in1_vld, in0_vld};
  assign opc = {in3_opcode, in2_opcode, in1_opcode, in0_opcode};
  assign data[0]  = in0_data;
  assign data[1]  = in1_data;
  assign data[2]  = in2_data;
  assign data[3]  = in3_data;
  assign sband[0] = in0_sideband;
  assign sband[1] = in1_sideband;
  assign sband[2] = in2_sideband;
  assign sband[3] = in3_sideband;
  assign src[0]   = in0_src_id;
  assign src[1]   = in1_src_id;
  assign src[2]   = in2_src_id;
  assign src[3]   = in3_src_id;
  assign tgt[0]   = in0_tgt_id;
  assign tgt[1]   = in1_tgt_id;
  assign tgt[2]   = in2_tgt_id;
  assign tgt[3]   = in3_tgt_id;

  // A requester is free when no valid requester is older than it.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      sel[i] = vld[i];
      for (int j = 0; j < N_IN; j++) begin
        if (j != i && age[i][j] && vld[j]) sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    lock_mask = '0;
    lock_mask[lock_id] = 1'b1;
  end

  assign grant    = (state == LOCKED) ? (vld & lock_mask) : sel;
  assign stg_rdy  = ~out_vld | out_rdy;
  assign rdy      = grant & {N_IN{stg_rdy}};
  assign accepted = |rdy;
  assign {in3_rdy, in2_rdy, in1_rdy, in0_rdy} = rdy;

  always_comb begin
    acc_idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (rdy[i]) acc_idx = 2'(i);
    end
  end

  assign acc_opc = opc[acc_idx];

  // Lock is taken on any accepted non-final beat and released by the final one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_id <= '0;
    end else if (accepted) begin
      if (acc_opc) begin
        state   <= LOCKED;
        lock_id <= acc_idx;
      end else begin
        state   <= IDLE;
      end
    end
  end

  // Completing a packet makes its requester the youngest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_IN; j++)
          age[i][j] <= (j < i);
    end else if (accepted && !acc_opc) begin
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_IN; j++)
          if (i == int'(acc_idx)) age[i][j] <= (j != i);
          else if (j == int'(acc_idx)) age[i][j] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld      <= 1'b0;
      out_opcode   <= 1'b0;
      out_data     <= '0;
      out_sideband <= '0;
      out_src_id   <= '0;
      out_tgt_id   <= '0;
      out_grant_id <= '0;
    end else if (accepted) begin
      out_vld      <= 1'b1;
      out_opcode   <= acc_opc;
      out_data     <= data[acc_idx];
      out_sideband <= sband[acc_idx];
      out_src_id   <= src[acc_idx];
      out_tgt_id   <= tgt[acc_idx];
      out_grant_id <= acc_idx;
    end else if (out_rdy) begin
      out_vld      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toy_bus_ack_arb4_locked.sv
// Bench for toy_bus_ack_arb4_locked: directed arbitration/lock/stall/reset steps,
// then a random packet stress, all checked through an output scoreboard.
module tb_toy_bus_ack_arb4_locked;
  localparam int DATA_W = 256;

  typedef struct {
    logic [1:0]        gid;
    logic              opc;
    logic [DATA_W-1:0] data;
    logic [9:0]        sb;
    logic [3:0]        src;
    logic [3:0]        tgt;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        tb_vld = '0;
  logic [3:0]        tb_opc = '0;
  logic              out_rdy = 1'b0;
  logic [DATA_W-1:0] tb_data [4];
  logic [9:0]        tb_sb   [4];
  logic [3:0]        tb_src  [4];
  logic [3:0]        tb_tgt  [4];
  wire  [3:0]        tb_rdy;
  logic              out_vld;
  logic              out_opcode;
  logic [DATA_W-1:0] out_data;
  logic [9:0]        out_sideband;
  logic [3:0]        out_src_id;
  logic [3:0]        out_tgt_id;
  logic [1:0]        out_grant_id;

  beat_t sb_q[$];
  int    beat_cnt [4];
  int    locked_req = -1;
  int    last_acc = -1;
  int    errors = 0;
  int    checks = 0;
  bit    active [4];
  bit    waiting [4];
  int    rem [4];
  int    wait_pk [4];

  toy_bus_ack_arb4_locked #(.N_IN(4), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_vld(tb_vld[0]), .in0_rdy(tb_rdy[0]), .in0_opcode(tb_opc[0]), .in0_data(tb_data[0]),
    .in0_sideband(tb_sb[0]), .in0_src_id(tb_src[0]), .in0_tgt_id(tb_tgt[0]),
    .in1_vld(tb_vld[1]), .in1_rdy(tb_rdy[1]), .in1_opcode(tb_opc[1]), .in1_data(tb_data[1]),
    .in1_sideband(tb_sb[1]), .in1_src_id(tb_src[1]), .in1_tgt_id(tb_tgt[1]),
    .in2_vld(tb_vld[2]), .in2_rdy(tb_rdy[2]), .in2_opcode(tb_opc[2]), .in2_data(tb_data[2]),
    .in2_sideband(tb_sb[2]), .in2_src_id(tb_src[2]), .in2_tgt_id(tb_tgt[2]),
    .in3_vld(tb_vld[3]), .in3_rdy(tb_rdy[3]), .in3_opcode(tb_opc[3]), .in3_data(tb_data[3]),
    .in3_sideband(tb_sb[3]), .in3_src_id(tb_src[3]), .in3_tgt_id(tb_tgt[3]),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_opcode(out_opcode), .out_data(out_data),
    .out_sideband(out_sideband), .out_src_id(out_src_id), .out_tgt_id(out_tgt_id),
    .out_grant_id(out_grant_id)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Payload is derived from requester index and its beat count, so every beat is unique.
  task automatic driveAll();
    for (int n = 0; n < 4; n++) begin
      tb_data[n] = {8{{8'(n), 24'(beat_cnt[n])}}};
      tb_sb[n]   = {2'(n), 8'(beat_cnt[n])};
      tb_src[n]  = 4'(n);
      tb_tgt[n]  = 4'(beat_cnt[n]);
    end
  endtask

  task automatic checkOutput();
    checkVal("out_vld_vs_scoreboard", out_vld, sb_q.size() != 0);
    if (out_vld && sb_q.size() != 0) begin
      checkVal("out_grant_id", out_grant_id, sb_q[0].gid);
      checkVal("out_opcode", out_opcode, sb_q[0].opc);
      checkVal("out_data", out_data, sb_q[0].data);
      checkVal("out_sideband", out_sideband, sb_q[0].sb);
      checkVal("out_src_id", out_src_id, sb_q[0].src);
      checkVal("out_tgt_id", out_tgt_id, sb_q[0].tgt);
      if (out_rdy) void'(sb_q.pop_front());
    end
  endtask

  task automatic captureAccepts();
    beat_t b;
    last_acc = -1;
    checkVal("rdy_onehot0", $onehot0(tb_rdy), 1);
    for (int n = 0; n < 4; n++) begin
      if (tb_vld[n] && tb_rdy[n]) begin
        last_acc = n;
        if (locked_req >= 0) checkVal("lock_contiguous", n, locked_req);
        b.gid  = 2'(n);
        b.opc  = tb_opc[n];
        b.data = tb_data[n];
        b.sb   = tb_sb[n];
        b.src  = tb_src[n];
        b.tgt  = tb_tgt[n];
        sb_q.push_back(b);
        beat_cnt[n]++;
        locked_req = tb_opc[n] ? n : -1;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] v, input logic [3:0] opc,
                               input logic ordy, input logic [3:0] exp_rdy, input bit chk);
    @(negedge clk);
    tb_vld  = v;
    tb_opc  = opc;
    out_rdy = ordy;
    driveAll();
    #1;
    checkOutput();
    if (chk) checkVal({tag, "_rdy"}, tb_rdy, exp_rdy);
    captureAccepts();
  endtask

  task automatic pulseReset();
    @(negedge clk);
    checkVal("pre_reset_out_vld", out_vld, 1);
    tb_vld = '0;
    #2 rst_n = 1'b0;
    #1;
    checkVal("async_reset_out_vld", out_vld, 0);
    checkVal("async_reset_out_data", out_data, 0);
    checkVal("async_reset_grant_id", out_grant_id, 0);
    sb_q.delete();
    locked_req = -1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    driveAll();
    repeat (2) @(negedge clk);
    checkVal("reset_out_vld", out_vld, 0);
    checkVal("reset_out_data", out_data, 0);
    checkVal("reset_out_grant_id", out_grant_id, 0);
    checkVal("reset_out_sideband", out_sideband, 0);
    checkVal("reset_out_opcode", out_opcode, 0);
    rst_n = 1'b1;

    // Round robin with everyone requesting single-beat packets.
    applyStimulus("rr0", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1);
    applyStimulus("rr1", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1);
    applyStimulus("rr2", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1);
    applyStimulus("rr3", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1);
    applyStimulus("rr4", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1);

    // in2 three-beat packet while in0 keeps requesting.
    applyStimulus("pkt2_b0", 4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1);
    applyStimulus("pkt2_b1", 4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1);
    applyStimulus("pkt2_b2", 4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1);
    applyStimulus("pkt2_in0", 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1);

    // in1 locked, drops valid for three cycles while in3 waits.
    applyStimulus("lk1_b0", 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1);
    applyStimulus("lk1_b1", 4'b1010, 4'b0010, 1'b1, 4'b0010, 1'b1);
    applyStimulus("lk1_gap0", 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b1);
    applyStimulus("lk1_gap1", 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b1);
    applyStimulus("lk1_gap2", 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b1);
    applyStimulus("lk1_last", 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1);
    applyStimulus("lk1_in3", 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1);

    // Locked young in1 holds off an older in0.
    applyStimulus("old_b0", 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1);
    applyStimulus("old_b1", 4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b1);
    applyStimulus("old_b2", 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1);
    applyStimulus("old_in0", 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1);

    // Output stall for five cycles, then drain and load together.
    applyStimulus("stall_ld", 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1);
    for (int k = 0; k < 5; k++)
      applyStimulus("stall", 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1);
    applyStimulus("unstall", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1);
    applyStimulus("drain", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1);

    // Reset mid-packet discards lock and output beat; lower index wins afterwards.
    applyStimulus("rst_lk", 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1);
    pulseReset();
    applyStimulus("post_rst", 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1);
    applyStimulus("post_rst3", 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1);

    // Random packets with random backpressure; starvation bounded by three packets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [3:0] v;
      logic [3:0] o;
      for (int n = 0; n < 4; n++) begin
        if (!active[n] && $urandom_range(0, 2) == 0) begin
          active[n]  = 1'b1;
          waiting[n] = 1'b1;
          rem[n]     = $urandom_range(1, 4);
          wait_pk[n] = 0;
        end
        v[n] = active[n];
        o[n] = active[n] && rem[n] > 1;
      end
      applyStimulus("stress", v, o, $urandom_range(0, 3) != 0, 4'b0000, 1'b0);
      if (last_acc >= 0) begin
        waiting[last_acc] = 1'b0;
        rem[last_acc]--;
        if (rem[last_acc] == 0) begin
          active[last_acc] = 1'b0;
          for (int m = 0; m < 4; m++) begin
            if (m != last_acc && waiting[m]) begin
              wait_pk[m]++;
              checkVal("starvation_bound", wait_pk[m] <= 3, 1);
            end
          end
        end
      end
    end

    // Let any unfinished packets complete, then drain the output.
    for (int cyc = 0; cyc < 40; cyc++) begin
      logic [3:0] v;
      logic [3:0] o;
      for (int n = 0; n < 4; n++) begin
        v[n] = active[n];
        o[n] = active[n] && rem[n] > 1;
      end
      applyStimulus("finish", v, o, 1'b1, 4'b0000, 1'b0);
      if (last_acc >= 0) begin
        rem[last_acc]--;
        if (rem[last_acc] == 0) active[last_acc] = 1'b0;
      end
    end
    checkVal("final_scoreboard_empty", sb_q.size(), 0);
    checkVal("final_unlocked", locked_req, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
